// File: rtl/jump_resolve_if.sv
// Decode-to-resolve handshake bundle: instruction in, resolved jump/branch out.
interface jump_resolve_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction_code;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      rd;
    logic            rd_we;
    logic [XLEN-1:0] rd_wdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            misaligned;
    logic            illegal;

    modport master (
        output in_valid, instruction_code, pc, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, rd, rd_we, rd_wdata, redirect,
        input  redirect_pc, misaligned, illegal
    );

    modport slave (
        input  in_valid, instruction_code, pc, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, rd, rd_we, rd_wdata, redirect,
        output redirect_pc, misaligned, illegal
    );
endinterface

// File: rtl/jump_resolve_stage.sv
// Registered JAL/JALR/branch resolution with fixed-depth wrong-path squash.
module jump_resolve_stage #(
    parameter int XLEN         = 32,
    parameter int SQUASH_DEPTH = 2,
    parameter int C_EXT        = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    jump_resolve_if.slave   bus
);
    localparam logic [2:0] SQ = 3'(SQUASH_DEPTH);

    typedef enum logic {RUN, SQUASH} state_t;

    state_t          state, state_n;
    logic [2:0]      sq_cnt, sq_n;
    logic            out_valid, ov_n, cap, in_ready;

    logic [4:0]      r_rd;
    logic            r_we, r_red, r_mis, r_ill;
    logic [XLEN-1:0] r_wd, r_rpc;

    logic [31:0]     ins;
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [4:0]      rd;
    logic            is_jal, is_jalr, is_br;
    logic [XLEN-1:0] imm_j, imm_i, imm_b, seq, jalr_sum, tgt;
    logic            taken, c_ill, c_xfer, c_mis, c_red, c_we;

    assign ins     = bus.instruction_code;
    assign opc     = ins[6:0];
    assign f3      = ins[14:12];
    assign rd      = ins[11:7];
    assign is_jal  = opc == 7'b1101111;
    assign is_jalr = opc == 7'b1100111;
    assign is_br   = opc == 7'b1100011;

    assign imm_j = {{(XLEN-20){ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    assign imm_i = {{(XLEN-11){ins[31]}}, ins[30:20]};
    assign imm_b = {{(XLEN-12){ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};

    assign seq      = bus.pc + XLEN'(4);
    assign jalr_sum = bus.rs1_data + imm_i;

    always_comb begin
        taken = 1'b0;
        case (f3)
            3'b000:  taken = bus.rs1_data == bus.rs2_data;
            3'b001:  taken = bus.rs1_data != bus.rs2_data;
            3'b100:  taken = $signed(bus.rs1_data) < $signed(bus.rs2_data);
            3'b101:  taken = $signed(bus.rs1_data) >= $signed(bus.rs2_data);
            3'b110:  taken = bus.rs1_data < bus.rs2_data;
            3'b111:  taken = bus.rs1_data >= bus.rs2_data;
            default: taken = 1'b0;
        endcase
    end

    // Non-transferring results (not-taken, illegal, pass-through) point at pc+4.
    always_comb begin
        c_ill  = 1'b0;
        c_xfer = 1'b0;
        tgt    = seq;
        unique case (1'b1)
            is_jal: begin
                c_xfer = 1'b1;
                tgt    = bus.pc + imm_j;
            end
            is_jalr: begin
                c_ill  = f3 != 3'b000;
                c_xfer = !c_ill;
                if (!c_ill) tgt = jalr_sum & ~XLEN'(1);
            end
            is_br: begin
                c_ill  = (f3 == 3'b010) || (f3 == 3'b011);
                c_xfer = !c_ill && taken;
                if (c_xfer) tgt = bus.pc + imm_b;
            end
            default: ;
        endcase
        c_mis = c_xfer && tgt[1] && (C_EXT == 0);
        c_red = c_xfer && !c_mis;
        c_we  = (is_jal || is_jalr) && !c_ill && !c_mis && (rd != 5'd0);
    end

    assign in_ready = (state == SQUASH) || !out_valid || bus.out_ready;

    always_comb begin
        state_n = state;
        sq_n    = sq_cnt;
        ov_n    = out_valid;
        cap     = 1'b0;
        if (out_valid && bus.out_ready) ov_n = 1'b0;
        if (flush) begin
            ov_n    = 1'b0;
            sq_n    = 3'd0;
            state_n = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (bus.in_valid && in_ready) begin
                        cap  = 1'b1;
                        ov_n = 1'b1;
                        if (c_red) begin
                            sq_n = SQ;
                            if (SQ != 3'd0) state_n = SQUASH;
                        end
                    end
                end
                SQUASH: begin
                    if (bus.in_valid) begin
                        sq_n = sq_cnt - 3'd1;
                        if (sq_cnt == 3'd1) state_n = RUN;
                    end
                end
                default: state_n = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            sq_cnt    <= 3'd0;
            out_valid <= 1'b0;
            r_rd      <= 5'd0;
            r_we      <= 1'b0;
            r_wd      <= '0;
            r_red     <= 1'b0;
            r_rpc     <= '0;
            r_mis     <= 1'b0;
            r_ill     <= 1'b0;
        end else begin
            state     <= state_n;
            sq_cnt    <= sq_n;
            out_valid <= ov_n;
            if (cap) begin
                r_rd  <= rd;
                r_we  <= c_we;
                r_wd  <= seq;
                r_red <= c_red;
                r_rpc <= tgt;
                r_mis <= c_mis;
                r_ill <= c_ill;
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.rd          = r_rd;
    assign bus.rd_we       = r_we;
    assign bus.rd_wdata    = r_wd;
    assign bus.redirect    = r_red;
    assign bus.redirect_pc = r_rpc;
    assign bus.misaligned  = r_mis;
    assign bus.illegal     = r_ill;
endmodule
